// File: rtl/animation_sequencer.sv
// Intro animation sequencer: counts vsync frames and steps through the ladder,
// platform and four-ramp tilt stages before reporting completion.
module animation_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  logic       vsync,
    input  logic       skip,
    output logic       ladder_en,
    output logic       platform_start,
    output logic [3:0] ramp_en,
    output logic       anim_busy,
    output logic       anim_done
);

    localparam int unsigned CW = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LADDER,
        S_PLATFORM,
        S_RAMP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic [3:0]      ramp_q, ramp_d;
    logic            vsync_q;
    logic            frame_tick;
    logic            busy;
    logic            step_end;

    assign frame_tick = vsync_q & ~vsync;
    assign busy       = (state_q == S_LADDER) || (state_q == S_PLATFORM) || (state_q == S_RAMP);
    assign step_end   = busy && frame_tick && (fcnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            ramp_q  <= '0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            ramp_q  <= ramp_d;
            vsync_q <= vsync;
        end
    end

    // Priority within busy states: abort, then skip, then step end, then count.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        ramp_d  = ramp_q;
        unique case (state_q)
            S_IDLE: begin
                fcnt_d = '0;
                ramp_d = '0;
                if (start_game) state_d = S_LADDER;
            end
            S_LADDER, S_PLATFORM, S_RAMP: begin
                if (!start_game) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                    ramp_d  = '0;
                end else if (skip) begin
                    state_d = S_DONE;
                    fcnt_d  = '0;
                    ramp_d  = '1;
                end else if (step_end) begin
                    fcnt_d = '0;
                    if (state_q == S_LADDER) begin
                        state_d = S_PLATFORM;
                    end else if (state_q == S_PLATFORM) begin
                        state_d = S_RAMP;
                        ramp_d  = 4'b0001;
                    end else if (ramp_q == 4'b1111) begin
                        state_d = S_DONE;
                    end else begin
                        ramp_d = {ramp_q[2:0], 1'b1};
                    end
                end else if (frame_tick) begin
                    fcnt_d = fcnt_q + CW'(1);
                end
            end
            S_DONE: begin
                fcnt_d = '0;
                ramp_d = '1;
                if (!start_game) begin
                    state_d = S_IDLE;
                    ramp_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                fcnt_d  = '0;
                ramp_d  = '0;
            end
        endcase
    end

    always_comb begin
        ladder_en      = 1'b0;
        platform_start = 1'b0;
        anim_busy      = busy;
        anim_done      = 1'b0;
        ramp_en        = ramp_q;
        unique case (state_q)
            S_LADDER:   ladder_en = 1'b1;
            S_PLATFORM, S_RAMP: begin
                ladder_en      = 1'b1;
                platform_start = 1'b1;
            end
            S_DONE: begin
                ladder_en      = 1'b1;
                platform_start = 1'b1;
                anim_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_animation_sequencer.sv
// Directed scoreboard bench for animation_sequencer with FRAMES_PER_STEP = 2.
module tb_animation_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_game;
    logic       vsync;
    logic       skip;
    logic       ladder_en;
    logic       platform_start;
    logic [3:0] ramp_en;
    logic       anim_busy;
    logic       anim_done;

    animation_sequencer #(.FRAMES_PER_STEP(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_game     (start_game),
        .vsync          (vsync),
        .skip           (skip),
        .ladder_en      (ladder_en),
        .platform_start (platform_start),
        .ramp_en        (ramp_en),
        .anim_busy      (anim_busy),
        .anim_done      (anim_done)
    );

    always #5 clk = ~clk;

    // Packed observation: {ladder_en, platform_start, ramp_en, anim_busy, anim_done}
    localparam logic [7:0] O_IDLE = 8'b0_0_0000_0_0;
    localparam logic [7:0] O_LAD  = 8'b1_0_0000_1_0;
    localparam logic [7:0] O_PLAT = 8'b1_1_0000_1_0;
    localparam logic [7:0] O_R1   = 8'b1_1_0001_1_0;
    localparam logic [7:0] O_R2   = 8'b1_1_0011_1_0;
    localparam logic [7:0] O_R3   = 8'b1_1_0111_1_0;
    localparam logic [7:0] O_R4   = 8'b1_1_1111_1_0;
    localparam logic [7:0] O_DONE = 8'b1_1_1111_0_1;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] stage_o [7];

    function automatic logic [7:0] observe();
        return {ladder_en, platform_start, ramp_en, anim_busy, anim_done};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_o(input string tag, input logic [7:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        sb_entry_t  e;
        logic [7:0] obs;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed empty queue, expected an entry");
        end else begin
            e   = sb_q.pop_front();
            obs = observe();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
            end
        end
    endtask

    // One 20-cycle vsync period ending on the falling edge; returns once the
    // edge sampling the tick has been applied.
    task automatic tick_frame(input logic sk);
        vsync = 1'b0;
        step(9);
        vsync = 1'b1;
        step(10);
        vsync = 1'b0;
        skip  = sk;
        step(1);
        skip  = 1'b0;
    endtask

    task automatic run_full(input string tag);
        for (int i = 1; i <= 12; i++) begin
            expect_o($sformatf("%s_tick%0d", tag, i), stage_o[i / 2]);
            tick_frame(1'b0);
            check_pop();
        end
    endtask

    initial begin
        stage_o[0] = O_LAD;
        stage_o[1] = O_PLAT;
        stage_o[2] = O_R1;
        stage_o[3] = O_R2;
        stage_o[4] = O_R3;
        stage_o[5] = O_R4;
        stage_o[6] = O_DONE;

        rst = 1'b1; start_game = 1'b1; vsync = 1'b0; skip = 1'b0;

        // Reset with start_game high and vsync toggling
        vsync = 1'b1;
        expect_o("reset_c1", O_IDLE); step(1); check_pop();
        vsync = 1'b0;
        expect_o("reset_c2", O_IDLE); step(1); check_pop();
        rst = 1'b0;
        expect_o("reset_release", O_LAD); step(1); check_pop();

        // Full sequence, then DONE holds for five more frames
        run_full("full");
        for (int i = 0; i < 5; i++) begin
            expect_o($sformatf("done_hold%0d", i), O_DONE);
            tick_frame(1'b0);
            check_pop();
        end
        skip = 1'b1;
        expect_o("skip_in_done", O_DONE); step(1); check_pop();
        skip = 1'b0;
        start_game = 1'b0;
        expect_o("done_to_idle", O_IDLE); step(1); check_pop();
        skip = 1'b1;
        expect_o("skip_in_idle", O_IDLE); step(1); check_pop();
        skip = 1'b0;

        // Skip during PLATFORM
        start_game = 1'b1;
        expect_o("skip_start", O_LAD); step(1); check_pop();
        tick_frame(1'b0);
        expect_o("skip_plat", O_PLAT); tick_frame(1'b0); check_pop();
        skip = 1'b1;
        expect_o("skip_done", O_DONE); step(1); check_pop();
        expect_o("skip_again", O_DONE); step(1); check_pop();
        skip = 1'b0;
        expect_o("skip_hold", O_DONE); step(3); check_pop();
        start_game = 1'b0;
        expect_o("skip_idle", O_IDLE); step(1); check_pop();

        // Abort while ramp_en = 0011, then full restart
        start_game = 1'b1;
        expect_o("abort_start", O_LAD); step(1); check_pop();
        repeat (5) tick_frame(1'b0);
        expect_o("abort_r2", O_R2); tick_frame(1'b0); check_pop();
        start_game = 1'b0;
        expect_o("abort_idle", O_IDLE); step(1); check_pop();
        start_game = 1'b1;
        expect_o("restart_lad", O_LAD); step(1); check_pop();
        run_full("restart");

        // skip with start_game low in the same cycle: abort wins
        start_game = 1'b0;
        expect_o("sim_idle0", O_IDLE); step(1); check_pop();
        start_game = 1'b1;
        expect_o("sim_lad0", O_LAD); step(1); check_pop();
        tick_frame(1'b0);
        skip = 1'b1; start_game = 1'b0;
        expect_o("skip_and_abort", O_IDLE); step(1); check_pop();
        skip = 1'b0;

        // skip on a step-end tick: skip wins
        start_game = 1'b1;
        expect_o("sim_lad1", O_LAD); step(1); check_pop();
        tick_frame(1'b0);
        expect_o("skip_on_step_end", O_DONE); tick_frame(1'b1); check_pop();
        start_game = 1'b0;
        expect_o("sim_idle1", O_IDLE); step(1); check_pop();

        // Tick coinciding with IDLE->LADDER is not counted
        vsync = 1'b1;
        step(10);
        vsync = 1'b0; start_game = 1'b1;
        expect_o("aligned_start", O_LAD); step(1); check_pop();
        expect_o("aligned_tick1", O_LAD); tick_frame(1'b0); check_pop();
        expect_o("aligned_tick2", O_PLAT); tick_frame(1'b0); check_pop();

        // Static vsync mid-LADDER holds state and count
        start_game = 1'b0;
        expect_o("static_idle", O_IDLE); step(1); check_pop();
        start_game = 1'b1;
        expect_o("static_lad", O_LAD); step(1); check_pop();
        tick_frame(1'b0);
        vsync = 1'b1;
        expect_o("static_hold", O_LAD); step(1000); check_pop();
        vsync = 1'b0;
        expect_o("static_resume", O_PLAT); step(1); check_pop();

        // Reset mid-sequence, start_game still high
        rst = 1'b1;
        expect_o("midreset", O_IDLE); step(1); check_pop();
        rst = 1'b0;
        expect_o("midreset_release", O_LAD); step(1); check_pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
